// File: rtl/demultiplexer8_deser.sv
// demultiplexer8_deser: LSB-first 1-to-8 bit deserializer with valid/ready output, flush and
// a one-word holding slot so the serial side can finish a word while the output is stalled.
module demultiplexer8_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] slot
);
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
    state_t     state_q;
    logic [2:0] slot_q;
    logic [7:0] asm_q, asm_d, out_data_q;
    logic       out_valid_q;
    always_comb begin
        asm_d = asm_q;
        asm_d[slot_q] = in;
    end
    assign in_ready  = rst_n && state_q != FULL && !flush;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            slot_q      <= 3'd0;
            asm_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;
            if (state_q == FULL) begin
                if (out_ready) begin
                    out_data_q  <= asm_q;
                    out_valid_q <= 1'b1;
                    asm_q       <= 8'h00;
                    state_q     <= EMPTY;
                end
            end else if (flush) begin
                slot_q  <= 3'd0;
                asm_q   <= 8'h00;
                state_q <= EMPTY;
            end else if (in_valid && in_ready) begin
                slot_q <= slot_q + 3'd1;
                if (slot_q != 3'd7) begin
                    asm_q   <= asm_d;
                    state_q <= PARTIAL;
                end else if (!out_valid_q || out_ready) begin
                    out_data_q  <= asm_d;
                    out_valid_q <= 1'b1;
                    asm_q       <= 8'h00;
                    state_q     <= EMPTY;
                end else begin
                    // output still occupied: park the finished word until the consumer frees it
                    asm_q   <= asm_d;
                    state_q <= FULL;
                end
            end
        end
    end
endmodule

// File: tb/tb_demultiplexer8_deser.sv
// tb_demultiplexer8_deser: directed vector table, async reset sequences and a random scoreboard run.
module tb_demultiplexer8_deser;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] slot;
    int checks = 0, failures = 0;

    demultiplexer8_deser dut (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .slot(slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b, iv, fl, ordy, ir, ov;
        logic [7:0] od;
        logic [2:0] sl;
    } vec_t;
    vec_t vt[$];

    function automatic void add(logic b, logic iv, logic fl, logic ordy, logic ir, logic ov,
                                logic [7:0] od, logic [2:0] sl);
        vec_t v;
        v.b = b; v.iv = iv; v.fl = fl; v.ordy = ordy; v.ir = ir; v.ov = ov; v.od = od; v.sl = sl;
        vt.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ir", in_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_slot", slot, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(logic [7:0] w, logic ordy);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in = w[k]; in_valid = 1'b1; flush = 1'b0; out_ready = ordy;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle_no_emit(string name);
        logic seen;
        seen = 1'b0;
        out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk(name, seen, 0);
    endtask

    logic [7:0] q[$];
    logic [7:0] part, prev_od, exp_w;
    logic       stall;
    int         cnt;

    initial begin
        // 4D then A5 back to back, out_ready held high
        add(1,1,0,1, 1, 0,8'h00,1); add(0,1,0,1, 1, 0,8'h00,2);
        add(1,1,0,1, 1, 0,8'h00,3); add(1,1,0,1, 1, 0,8'h00,4);
        add(0,1,0,1, 1, 0,8'h00,5); add(0,1,0,1, 1, 0,8'h00,6);
        add(1,1,0,1, 1, 0,8'h00,7); add(0,1,0,1, 1, 1,8'h4D,0);
        add(1,1,0,1, 1, 0,8'h4D,1); add(0,1,0,1, 1, 0,8'h4D,2);
        add(1,1,0,1, 1, 0,8'h4D,3); add(0,1,0,1, 1, 0,8'h4D,4);
        add(0,1,0,1, 1, 0,8'h4D,5); add(1,1,0,1, 1, 0,8'h4D,6);
        add(0,1,0,1, 1, 0,8'h4D,7); add(1,1,0,1, 1, 1,8'hA5,0);
        add(0,0,0,1, 1, 0,8'hA5,0);
        // out_ready low: 4D then 3C, second word parks in FULL
        add(1,1,0,0, 1, 0,8'hA5,1); add(0,1,0,0, 1, 0,8'hA5,2);
        add(1,1,0,0, 1, 0,8'hA5,3); add(1,1,0,0, 1, 0,8'hA5,4);
        add(0,1,0,0, 1, 0,8'hA5,5); add(0,1,0,0, 1, 0,8'hA5,6);
        add(1,1,0,0, 1, 0,8'hA5,7); add(0,1,0,0, 1, 1,8'h4D,0);
        add(0,1,0,0, 1, 1,8'h4D,1); add(0,1,0,0, 1, 1,8'h4D,2);
        add(1,1,0,0, 1, 1,8'h4D,3); add(1,1,0,0, 1, 1,8'h4D,4);
        add(1,1,0,0, 1, 1,8'h4D,5); add(1,1,0,0, 1, 1,8'h4D,6);
        add(0,1,0,0, 1, 1,8'h4D,7); add(0,1,0,0, 1, 1,8'h4D,0);
        add(1,1,1,0, 0, 1,8'h4D,0);
        add(0,0,1,1, 0, 1,8'h3C,0);
        add(0,0,0,1, 1, 0,8'h3C,0);
        // three bits, flush with in_valid, then FF
        add(1,1,0,1, 1, 0,8'h3C,1); add(1,1,0,1, 1, 0,8'h3C,2);
        add(1,1,0,1, 1, 0,8'h3C,3); add(0,1,1,1, 0, 0,8'h3C,0);
        add(1,1,0,1, 1, 0,8'h3C,1); add(1,1,0,1, 1, 0,8'h3C,2);
        add(1,1,0,1, 1, 0,8'h3C,3); add(1,1,0,1, 1, 0,8'h3C,4);
        add(1,1,0,1, 1, 0,8'h3C,5); add(1,1,0,1, 1, 0,8'h3C,6);
        add(1,1,0,1, 1, 0,8'h3C,7); add(1,1,0,1, 1, 1,8'hFF,0);
        add(0,0,1,0, 0, 1,8'hFF,0); add(0,0,0,1, 1, 0,8'hFF,0);

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            in = vt[i].b; in_valid = vt[i].iv; flush = vt[i].fl; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].ir);
            @(posedge clk); #1;
            chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].ov);
            chk($sformatf("v%0d_out_data", i), out_data, vt[i].od);
            chk($sformatf("v%0d_slot", i), slot, vt[i].sl);
        end

        // async reset after 5 bits, between edges
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("mid_rst_slot", slot, 0);
        chk("mid_rst_ir", in_ready, 0);
        chk("mid_rst_ov", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b1;
        idle_no_emit("mid_rst_no_emit");

        // async reset while FULL
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #1;
        chk("full_ir", in_ready, 0);
        chk("full_od", out_data, 8'h11);
        #2;
        rst_n = 1'b0; #1;
        chk("full_rst_ov", out_valid, 0);
        chk("full_rst_od", out_data, 0);
        chk("full_rst_slot", slot, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_no_emit("full_rst_no_emit");

        // first accept after release lands in slot 0
        send(8'hC3, 1'b1);
        #1;
        chk("post_rst_ov", out_valid, 1);
        chk("post_rst_od", out_data, 8'hC3);

        // random traffic against a bit-counting scoreboard
        do_reset();
        cnt = 0; part = 8'h00; stall = 1'b0; prev_od = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (c < 9980) begin
                in = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
                flush = ($urandom_range(0, 31) == 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
            end
            #1;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_od);
            end
            if (flush) chk("flush_ir", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("rand_pop_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    chk("rand_word", out_data, exp_w);
                end
            end
            if (in_valid && in_ready) begin
                part[cnt[2:0]] = in;
                cnt++;
                if (cnt == 8) begin
                    q.push_back(part);
                    cnt = 0;
                end
            end else if (flush) cnt = 0;
            stall = out_valid && !out_ready;
            prev_od = out_data;
        end
        chk("rand_drained", q.size(), 0);
        chk("rand_final_ov", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demultiplexer8_deser.md
DEMULTIPLEXER8_DESER -- requirements
Module: demultiplexer8_deser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset, released synchronously by the environment.
REQ-004 in  input  1  serial data bit.
REQ-005 in_valid  input  1  in carries a bit this cycle.
REQ-006 in_ready  output  1  block accepts a bit this cycle.
REQ-007 flush  input  1  discard the partially assembled word.
REQ-008 out_data  output  8  assembled word; bit k is the k-th accepted bit (slot k).
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 slot  output  3  index {a2,a1,a0} of the slot the next accepted bit is written to; a0 is the LSB.

Function
REQ-012 A bit SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in and in_valid are ignored otherwise.
REQ-013 The block SHALL write an accepted bit into assembly slot slot, then increment slot modulo 8 (7 wraps to 0).
REQ-014 The block SHALL hold three states: EMPTY (slot=0, no held word), PARTIAL (slot!=0), FULL (8-bit word held in assembly, output occupied).
REQ-015 EMPTY->PARTIAL on accept; PARTIAL->PARTIAL on accept with slot<7.
REQ-016 On accept at slot=7, if out_valid=0 or out_ready=1 that cycle, the word {in, slots 6..0} SHALL load out_data and set out_valid on that edge, and the state SHALL return to EMPTY.
REQ-017 On accept at slot=7 with out_valid=1 and out_ready=0, the complete word SHALL be held in assembly and the state SHALL go to FULL.
REQ-018 in_ready SHALL be 0 in FULL and whenever flush=1, and 1 otherwise (combinational from state and flush).
REQ-019 In FULL, on a cycle with out_ready=1, the held word SHALL move to out_data, out_valid SHALL stay 1, and the state SHALL go to EMPTY.
REQ-020 A cycle with out_valid=1, out_ready=1 and no new word loading out_data SHALL clear out_valid on that edge.
REQ-021 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 flush=1 in PARTIAL or EMPTY SHALL reset slot to 0 and discard partial bits on that edge; flush SHALL NOT affect a FULL held word, out_data or out_valid.
REQ-023 Simultaneous flush and in_valid SHALL discard the bit, because in_ready=0.
REQ-024 Latency SHALL be 1 cycle from the edge accepting bit 7 to out_valid=1 when the output is free.
REQ-025 Sustained throughput SHALL be one bit per cycle, one word per 8 cycles, with out_ready held at 1.
REQ-026 Bits SHALL be assembled LSB-first; no bit reordering or inversion.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force state EMPTY, slot=0, out_valid=0, out_data=8'h00, and assembly slots to 0.
REQ-028 While rst_n=0, in_ready SHALL be 0.
REQ-029 Reset asserted mid-word or in FULL SHALL drop all partial and held data; nothing is emitted after release.
REQ-030 The first accept after release SHALL write slot 0.

Verification
REQ-031 Reset release, out_ready=1, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> out_valid=1 one cycle after the 8th accept, out_data=8'h4D, slot=0.
REQ-032 Back-to-back words 8'h4D then 8'hA5, out_ready=1 -> out_valid pulses on cycles 8 and 16, in_ready constant 1, no gap.
REQ-033 out_ready=0, send 8'h4D then 8'h3C -> out_data=8'h4D held, FULL entered, in_ready=0. Raise out_ready for 1 cycle -> out_data=8'h3C, in_ready=1 next cycle. Raise it again -> out_valid=0.
REQ-034 Send 3 bits, pulse flush with in_valid=1 -> slot=0 and that bit dropped; next 8 bits 0xFF -> out_data=8'hFF.
REQ-035 Assert rst_n=0 asynchronously between edges after 5 bits and in FULL -> outputs reset immediately, no word emitted after release.
REQ-036 Random in_valid/out_ready, 10k cycles -> words match reference model, no loss or duplication, out_data stable while stalled.
